// File: rtl/grant_dec_pkg.sv
// Shared types, widths and the one-hot decode for the grant decoder.
package grant_dec_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned GRANT_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Binary code to one-hot grant vector.
  function automatic logic [GRANT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    return GRANT_W'(1) << code;
  endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable hold/gap down-counter with a registered zero flag.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   load        - load load_value this cycle (wins over dec)
//   load_value  - value to load
//   dec         - decrement enable; saturates at zero
//   zero        - counter currently holds 0
module dec_hold_cnt
  import grant_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // zero tracks the value count takes at the same edge, so it stays a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_value;
      zero  <= (load_value == '0);
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/grant_decoder.sv
// Decodes an accepted 2-bit code into a one-hot grant held for HOLD_CYCLES,
// followed by GAP_CYCLES dead cycles before the next code is accepted.
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   code_in        - encoded index from the upstream priority encoder
//   code_valid     - code_in valid this cycle
//   code_ready     - block accepts a code this cycle (high only in IDLE)
//   grant_release  - early termination of the active grant
//   grant          - registered one-hot grant
//   grant_active   - registered (grant != 0)
//   grant_count    - grants issued, wraps modulo 256
module grant_decoder
  import grant_dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic               grant_release,
  output logic [GRANT_W-1:0] grant,
  output logic               grant_active,
  output logic [COUNT_W-1:0] grant_count
);

  localparam logic             HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t            state;
  logic [CODE_W-1:0] code_q;
  logic              cnt_zero;
  logic              transfer;
  logic              grant_exit;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_value;

  // Release and expiry collapse into one exit condition.
  assign transfer       = code_valid && code_ready;
  assign grant_exit     = (state == GRANT) && (cnt_zero || grant_release);
  assign cnt_load       = transfer || (grant_exit && HAS_GAP);
  assign cnt_load_value = transfer ? HOLD_LOAD : GAP_LOAD;
  assign cnt_dec        = ((state == GRANT) && !grant_exit) ||
                          ((state == GAP) && !cnt_zero);

  dec_hold_cnt u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // FSM with registered grant, ready and count outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      code_q       <= '0;
      grant        <= '0;
      grant_active <= 1'b0;
      grant_count  <= '0;
      code_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state        <= GRANT;
            code_q       <= code_in;
            grant        <= decode_onehot(code_in);
            grant_active <= 1'b1;
            code_ready   <= 1'b0;
            grant_count  <= grant_count + COUNT_W'(1);
          end
        end
        GRANT: begin
          if (grant_exit) begin
            grant        <= '0;
            grant_active <= 1'b0;
            if (HAS_GAP) begin
              state <= GAP;
            end else begin
              state      <= IDLE;
              code_ready <= 1'b1;
            end
          end else begin
            grant        <= decode_onehot(code_q);
            grant_active <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state      <= IDLE;
            code_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          grant        <= '0;
          grant_active <= 1'b0;
          code_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Directed bench: default-parameter instance plus a HOLD=1/GAP=0 instance.
module tb_grant_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] d_code, f_code;
  logic       d_valid, f_valid;
  logic       d_release, f_release;
  logic       d_ready, f_ready;
  logic [3:0] d_grant, f_grant;
  logic       d_active, f_active;
  logic [7:0] d_count, f_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  grant_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_in       (d_code),
    .code_valid    (d_valid),
    .code_ready    (d_ready),
    .grant_release (d_release),
    .grant         (d_grant),
    .grant_active  (d_active),
    .grant_count   (d_count)
  );

  grant_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_in       (f_code),
    .code_valid    (f_valid),
    .code_ready    (f_ready),
    .grant_release (f_release),
    .grant         (f_grant),
    .grant_active  (f_active),
    .grant_count   (f_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    d_code = 2'd0; d_valid = 1'b0; d_release = 1'b0;
    f_code = 2'd0; f_valid = 1'b0; f_release = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(d_grant), 32'h0);
    check("rst_active", 32'(d_active), 32'h0);
    check("rst_count", 32'(d_count), 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(d_ready), 32'h1);
    check("fast_ready_after_rst", 32'(f_ready), 32'h1);

    // Back-to-back on HOLD=1/GAP=0 with valid held: codes 0 then 2.
    f_valid = 1'b1; f_code = 2'd0;
    tick();
    check("b2b_g0", 32'(f_grant), 32'h1);
    check("b2b_act0", 32'(f_active), 32'h1);
    check("b2b_rdy0", 32'(f_ready), 32'h0);
    f_code = 2'd2;
    tick();
    check("b2b_gap", 32'(f_grant), 32'h0);
    check("b2b_rdy1", 32'(f_ready), 32'h1);
    tick();
    check("b2b_g2", 32'(f_grant), 32'h4);
    check("b2b_count", 32'(f_count), 32'h2);
    f_valid = 1'b0;
    tick();
    check("b2b_idle", 32'(f_grant), 32'h0);

    // Release coinciding with expiry, no gap configured.
    f_code = 2'd3; f_valid = 1'b1;
    tick();
    f_valid = 1'b0; f_release = 1'b1;
    check("fsim_grant", 32'(f_grant), 32'h8);
    tick();
    f_release = 1'b0;
    check("fsim_exit", 32'(f_grant), 32'h0);
    check("fsim_ready", 32'(f_ready), 32'h1);
    check("fsim_count", 32'(f_count), 32'h3);

    // Release in IDLE is ignored.
    d_release = 1'b1;
    tick();
    d_release = 1'b0;
    check("idle_rel_grant", 32'(d_grant), 32'h0);
    check("idle_rel_ready", 32'(d_ready), 32'h1);

    // Basic: code 3 held for 4 cycles, one gap cycle.
    d_code = 2'd3; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    check("basic_count", 32'(d_count), 32'h1);
    check("basic_ready", 32'(d_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_g%0d", i), 32'(d_grant), 32'h8);
      check($sformatf("basic_a%0d", i), 32'(d_active), 32'h1);
      tick();
    end
    check("basic_gap_grant", 32'(d_grant), 32'h0);
    check("basic_gap_ready", 32'(d_ready), 32'h0);
    tick();
    check("basic_ready_back", 32'(d_ready), 32'h1);
    check("basic_count_end", 32'(d_count), 32'h1);

    // Early release in the 2nd grant cycle.
    d_code = 2'd1; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    check("rel_g1", 32'(d_grant), 32'h2);
    tick();
    check("rel_g2", 32'(d_grant), 32'h2);
    d_release = 1'b1;
    tick();
    d_release = 1'b0;
    check("rel_gap_grant", 32'(d_grant), 32'h0);
    check("rel_gap_ready", 32'(d_ready), 32'h0);
    tick();
    check("rel_ready", 32'(d_ready), 32'h1);
    check("rel_count", 32'(d_count), 32'h2);

    // Release on the final hold cycle still gives one gap cycle.
    d_code = 2'd0; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sim_g%0d", i), 32'(d_grant), 32'h1);
      tick();
    end
    check("sim_g3", 32'(d_grant), 32'h1);
    d_release = 1'b1;
    tick();
    d_release = 1'b0;
    check("sim_gap_grant", 32'(d_grant), 32'h0);
    check("sim_gap_ready", 32'(d_ready), 32'h0);
    tick();
    check("sim_ready", 32'(d_ready), 32'h1);
    check("sim_count", 32'(d_count), 32'h3);

    // Held valid: code latched at transfer, next accepted at first IDLE cycle.
    d_code = 2'd2; d_valid = 1'b1;
    tick();
    d_code = 2'd3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_g%0d", i), 32'(d_grant), 32'h4);
      tick();
    end
    check("hold_gap", 32'(d_grant), 32'h0);
    tick();
    check("hold_idle_ready", 32'(d_ready), 32'h1);
    check("hold_idle_grant", 32'(d_grant), 32'h0);
    tick();
    d_valid = 1'b0;
    check("hold_second", 32'(d_grant), 32'h8);
    check("hold_count", 32'(d_count), 32'h5);

    // Mid-grant reset in the 3rd grant cycle.
    tick(); tick();
    check("mrst_pre", 32'(d_grant), 32'h8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_grant", 32'(d_grant), 32'h0);
    check("mrst_active", 32'(d_active), 32'h0);
    check("mrst_count", 32'(d_count), 32'h0);
    check("mrst_ready", 32'(d_ready), 32'h1);

    // Wrap: held valid transfers every 6 cycles, first at the next edge.
    d_code = 2'd1; d_valid = 1'b1;
    repeat (1525) tick();
    check("wrap_255", 32'(d_count), 32'hff);
    repeat (6) tick();
    d_valid = 1'b0;
    check("wrap_0", 32'(d_count), 32'h0);
    repeat (6) tick();
    check("wrap_idle", 32'(d_ready), 32'h1);
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    check("wrap_1", 32'(d_count), 32'h1);
    check("wrap_grant", 32'(d_grant), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles a grant is held; the legal range is 1..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving the number of dead cycles after a grant; the legal range is 0..255.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with these ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- code_in  input  2  encoded index from the upstream priority encoder.
- code_valid  input  1  code_in is valid this cycle.
- code_ready  output  1  the block accepts a code this cycle.
- grant_release  input  1  early termination of the active grant.
- grant  output  4  registered one-hot decoded grant.
- grant_active  output  1  high while grant is non-zero.
- grant_count  output  8  total grants issued; wraps modulo 256.

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, GRANT and GAP.
REQ-005 A transfer SHALL occur on a rising edge where code_valid and code_ready are both 1.
REQ-006 code_ready SHALL be 1 only in IDLE, decoded from the state register with no combinational path from code_valid.
REQ-007 In IDLE, a transfer SHALL latch code_in, move to GRANT, and load the hold counter with HOLD_CYCLES-1.
REQ-008 grant SHALL equal 1 shifted left by the latched code, for example 2'b10 gives 4'b0100, in every cycle spent in GRANT, and SHALL be 4'b0000 in every other state.
REQ-009 Latency: for a transfer at edge N, grant SHALL be visible in the cycle after edge N and held for exactly HOLD_CYCLES cycles, absent a release.
REQ-010 In GRANT, the hold counter SHALL decrement each cycle; the edge at which the counter is 0 SHALL exit GRANT.
REQ-011 The GRANT exit SHALL go to GAP, with the counter loaded to GAP_CYCLES-1, if GAP_CYCLES>0, and otherwise SHALL go directly to IDLE.
REQ-012 In GAP, the counter SHALL decrement each cycle, and the edge at which it is 0 SHALL go to IDLE.
REQ-013 grant_release=1 sampled in GRANT SHALL exit GRANT at that edge exactly as counter expiry does, following REQ-011.
REQ-014 grant_release SHALL be ignored in IDLE and GAP.
REQ-015 grant_release and counter expiry at the same edge SHALL produce a single exit with no double counting and no skipped GAP.
REQ-016 code_valid outside IDLE SHALL be ignored; an upstream source that keeps code_valid asserted SHALL be accepted at the first IDLE cycle.
REQ-017 grant_count SHALL increment by 1 at each transfer edge and wrap from 255 to 0.
REQ-018 grant_active SHALL be registered and SHALL equal (grant != 0) in every cycle.
REQ-019 With HOLD_CYCLES=1 and GAP_CYCLES=0, the block SHALL sustain one transfer every 2 cycles.

Reset
REQ-020 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE, the counter and latched code SHALL be cleared to 0, and grant, grant_active and grant_count SHALL be cleared to 0.
REQ-021 Reset asserted during GRANT or GAP SHALL clear grant at that same edge, with no completion of the hold or gap.
REQ-022 code_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-023 The package grant_dec_pkg SHALL hold the FSM state type (IDLE, GRANT, GAP), CODE_W=2, GRANT_W=4, CNT_W=8 and COUNT_W=8.
REQ-024 The hold/gap down-counter SHALL be one sub-module, dec_hold_cnt, with inputs load, load_value and decrement enable and output zero flag.
REQ-025 The top level SHALL contain the FSM, the code latch, the one-hot decode and grant_count.

Verification
REQ-026 Basic: with defaults, code_in=2'b11 and code_valid=1 for one cycle SHALL give grant=4'b1000 for 4 cycles, then 1 cycle of 0, then code_ready=1; grant_count SHALL be 1.
REQ-027 Early release: with code 2'b01 accepted and grant_release=1 in the 2nd grant cycle, grant=4'b0010 SHALL last 2 cycles, then GAP for 1 cycle.
REQ-028 Back-to-back: with code_valid held for codes 0 then 2, HOLD_CYCLES=1 and GAP_CYCLES=0, grant SHALL be 4'b0001, 0, 4'b0100 on consecutive cycles.
REQ-029 Mid-grant reset: rst_n=0 in the 3rd grant cycle SHALL give grant=0, grant_count=0 and code_ready=1 in the next cycle.
REQ-030 Wrap: 256 transfers SHALL return grant_count to 0, and the 257th transfer SHALL read 1.
REQ-031 Simultaneous events: grant_release=1 on the final hold cycle SHALL still give exactly GAP_CYCLES gap cycles.
